// File: rtl/rob_retire_unit.sv
// rob_retire_unit: reorder buffer taking 2 renamed instructions per cycle and retiring up to 3 in order
// Optional feature macro: ROB_FLUSH_EN (adds i_flush, clears the whole ROB at the edge).
// Ports:
//   i_clk, i_rst_n                     clock, asynchronous active-low reset
//   i_disp_valid/pdst/old_pdst         2-slot dispatch, slot 0 older, slot k in bits [k*W +: W]
//   o_disp_ready, o_disp_idx           >=2 free entries; slot 0 index = tail, slot 1 index = tail+1
//   i_wb_valid, i_wb_idx               3 completion ports
//   o_ret_valid/pdst/old_pdst          registered retire lanes, lane 0 oldest
//   o_count                            occupied entries
module rob_retire_unit #(
  parameter int DEPTH  = 16,
  parameter int PREG_W = 7,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
`ifdef ROB_FLUSH_EN
  input  logic                  i_flush,
`endif
  input  logic [1:0]            i_disp_valid,
  input  logic [2*PREG_W-1:0]   i_disp_pdst,
  input  logic [2*PREG_W-1:0]   i_disp_old_pdst,
  output logic                  o_disp_ready,
  output logic [2*IDX_W-1:0]    o_disp_idx,
  input  logic [2:0]            i_wb_valid,
  input  logic [3*IDX_W-1:0]    i_wb_idx,
  output logic [2:0]            o_ret_valid,
  output logic [3*PREG_W-1:0]   o_ret_pdst,
  output logic [3*PREG_W-1:0]   o_ret_old_pdst,
  output logic [IDX_W:0]        o_count
);
  localparam int CW = IDX_W + 1;
  logic [DEPTH-1:0]    r_valid, r_done;
  logic [PREG_W-1:0]   r_pdst [DEPTH];
  logic [PREG_W-1:0]   r_old_pdst [DEPTH];
  logic [IDX_W-1:0]    r_head, r_tail;
  logic [IDX_W:0]      r_count;
  logic [2:0]          r_ret_valid;
  logic [3*PREG_W-1:0] r_ret_pdst, r_ret_old_pdst;
  logic                w_ready;
  logic [1:0]          w_disp_v, w_n_disp, w_n_ret;
  logic [IDX_W-1:0]    w_tail1, w_slot1_idx;
  logic [IDX_W-1:0]    w_ret_idx [3];
  logic [2:0]          w_rdy, w_ret;
  assign w_ready = (CW'(DEPTH) - r_count) >= CW'(2);
  assign w_tail1 = r_tail + IDX_W'(1);
`ifdef ROB_FLUSH_EN
  assign w_disp_v = i_disp_valid & {2{w_ready & ~i_flush}};
`else
  assign w_disp_v = i_disp_valid & {2{w_ready}};
`endif
  assign w_n_disp = {1'b0, w_disp_v[0]} + {1'b0, w_disp_v[1]};
  // a lone slot 1 is compacted onto the tail entry
  assign w_slot1_idx = w_disp_v[0] ? w_tail1 : r_tail;
  assign o_disp_ready = w_ready;
  assign o_disp_idx = {w_tail1, r_tail};
  assign o_ret_valid = r_ret_valid;
  assign o_ret_pdst = r_ret_pdst;
  assign o_ret_old_pdst = r_ret_old_pdst;
  assign o_count = r_count;
  // in-order retire: lane k only if every older lookahead entry also retires
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      w_ret_idx[k] = r_head + IDX_W'(k);
      w_rdy[k] = r_valid[w_ret_idx[k]] & r_done[w_ret_idx[k]];
    end
    w_ret = {&w_rdy, &w_rdy[1:0], w_rdy[0]};
    w_n_ret = {1'b0, w_ret[0]} + {1'b0, w_ret[1]} + {1'b0, w_ret[2]};
  end
  always_ff @(posedge i_clk) begin
    if (w_disp_v[0]) begin
      r_pdst[r_tail] <= i_disp_pdst[0 +: PREG_W];
      r_old_pdst[r_tail] <= i_disp_old_pdst[0 +: PREG_W];
    end
    if (w_disp_v[1]) begin
      r_pdst[w_slot1_idx] <= i_disp_pdst[PREG_W +: PREG_W];
      r_old_pdst[w_slot1_idx] <= i_disp_old_pdst[PREG_W +: PREG_W];
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= '0;
      r_done <= '0;
      r_head <= '0;
      r_tail <= '0;
      r_count <= '0;
      r_ret_valid <= '0;
      r_ret_pdst <= '0;
      r_ret_old_pdst <= '0;
`ifdef ROB_FLUSH_EN
    end else if (i_flush) begin
      r_valid <= '0;
      r_done <= '0;
      r_head <= '0;
      r_tail <= '0;
      r_count <= '0;
      r_ret_valid <= '0;
      r_ret_pdst <= '0;
      r_ret_old_pdst <= '0;
`endif
    end else begin
      r_head <= r_head + IDX_W'(w_n_ret);
      r_tail <= r_tail + IDX_W'(w_n_disp);
      r_count <= r_count + CW'(w_n_disp) - CW'(w_n_ret);
      r_ret_valid <= w_ret;
      for (int p = 0; p < 3; p++)
        if (i_wb_valid[p] && r_valid[i_wb_idx[p*IDX_W +: IDX_W]])
          r_done[i_wb_idx[p*IDX_W +: IDX_W]] <= 1'b1;
      for (int k = 0; k < 3; k++) begin
        r_ret_pdst[k*PREG_W +: PREG_W] <= w_ret[k] ? r_pdst[w_ret_idx[k]] : '0;
        r_ret_old_pdst[k*PREG_W +: PREG_W] <= w_ret[k] ? r_old_pdst[w_ret_idx[k]] : '0;
        if (w_ret[k]) begin
          r_valid[w_ret_idx[k]] <= 1'b0;
          r_done[w_ret_idx[k]] <= 1'b0;
        end
      end
      if (w_disp_v[0]) begin
        r_valid[r_tail] <= 1'b1;
        r_done[r_tail] <= 1'b0;
      end
      if (w_disp_v[1]) begin
        r_valid[w_slot1_idx] <= 1'b1;
        r_done[w_slot1_idx] <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_rob_retire_unit.sv
// tb_rob_retire_unit: table-driven directed bench for rob_retire_unit (DEPTH 16, PREG_W 7)
module tb_rob_retire_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] disp_valid;
  logic [13:0] disp_pdst, disp_old;
  logic disp_ready;
  logic [7:0] disp_idx;
  logic [2:0] wb_valid;
  logic [11:0] wb_idx;
  logic [2:0] ret_valid;
  logic [20:0] ret_pdst, ret_old;
  logic [4:0] count;
`ifdef ROB_FLUSH_EN
  logic flush = 1'b0;
`endif
  always #5 clk = ~clk;
  rob_retire_unit dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
`ifdef ROB_FLUSH_EN
    .i_flush(flush),
`endif
    .i_disp_valid(disp_valid),
    .i_disp_pdst(disp_pdst),
    .i_disp_old_pdst(disp_old),
    .o_disp_ready(disp_ready),
    .o_disp_idx(disp_idx),
    .i_wb_valid(wb_valid),
    .i_wb_idx(wb_idx),
    .o_ret_valid(ret_valid),
    .o_ret_pdst(ret_pdst),
    .o_ret_old_pdst(ret_old),
    .o_count(count)
  );
  typedef struct {
    logic [1:0] dv;
    logic [1:0][6:0] pd, od;
    logic [2:0] wv;
    logic [2:0][3:0] wi;
    logic [2:0] e_rv;
    logic [2:0][6:0] e_pd, e_od;
    logic [4:0] e_cnt;
    logic e_rdy;
    logic [1:0][3:0] e_didx;
  } vec_t;
  vec_t tbl [38];
  int n_chk = 0;
  int n_fail = 0;
  // entry i always carries pdst 32+i and old_pdst 64+i unless overridden
  function automatic vec_t mk(logic [1:0] dv, int d0, int d1, logic [2:0] wv, int w0, int w1, int w2,
                              logic [2:0] rv, int r0, int r1, int r2, int cnt, logic rdy, int tail);
    vec_t v;
    int d[2];
    int w[3];
    int r[3];
    d = '{d0, d1};
    w = '{w0, w1, w2};
    r = '{r0, r1, r2};
    v.dv = dv;
    v.wv = wv;
    v.e_rv = rv;
    v.e_cnt = 5'(cnt);
    v.e_rdy = rdy;
    for (int i = 0; i < 2; i++) begin
      v.pd[i] = 7'(32 + d[i]);
      v.od[i] = 7'(64 + d[i]);
      v.e_didx[i] = 4'((tail + i) % 16);
    end
    for (int i = 0; i < 3; i++) begin
      v.wi[i] = 4'(w[i]);
      v.e_pd[i] = rv[i] ? 7'(32 + r[i]) : 7'd0;
      v.e_od[i] = rv[i] ? 7'(64 + r[i]) : 7'd0;
    end
    return v;
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic drive(vec_t v);
    disp_valid = v.dv;
    disp_pdst = v.pd;
    disp_old = v.od;
    wb_valid = v.wv;
    wb_idx = v.wi;
  endtask
  task automatic idle();
    disp_valid = '0;
    disp_pdst = '0;
    disp_old = '0;
    wb_valid = '0;
    wb_idx = '0;
  endtask
  task automatic check_row(string tag, vec_t v);
    chk($sformatf("%s count", tag), 32'(count), 32'(v.e_cnt));
    chk($sformatf("%s ready", tag), 32'(disp_ready), 32'(v.e_rdy));
    chk($sformatf("%s disp_idx", tag), 32'(disp_idx), 32'(v.e_didx));
    chk($sformatf("%s ret_valid", tag), 32'(ret_valid), 32'(v.e_rv));
    chk($sformatf("%s ret_pdst", tag), 32'(ret_pdst), 32'(v.e_pd));
    chk($sformatf("%s ret_old", tag), 32'(ret_old), 32'(v.e_od));
  endtask
  task automatic apply(string tag, vec_t v);
    drive(v);
    @(posedge clk);
    @(negedge clk);
    check_row(tag, v);
  endtask
  initial begin
    vec_t f;
    //             dv    d0 d1 wv     w0 w1 w2 rv     r0 r1 r2 cnt rdy tail
    tbl[0]  = mk(2'b11, 0, 1, 3'b000, 0, 0, 0, 3'b000, 0, 0, 0, 2, 1, 2);
    tbl[0].od[0] = 7'd5;
    tbl[0].od[1] = 7'd6;
    tbl[1]  = mk(2'b00, 0, 0, 3'b001, 1, 0, 0, 3'b000, 0, 0, 0, 2, 1, 2);
    tbl[2]  = mk(2'b00, 0, 0, 3'b001, 0, 0, 0, 3'b000, 0, 0, 0, 2, 1, 2);
    tbl[3]  = mk(2'b00, 0, 0, 3'b000, 0, 0, 0, 3'b011, 0, 1, 0, 0, 1, 2);
    tbl[3].e_od[0] = 7'd5;
    tbl[3].e_od[1] = 7'd6;
    tbl[4]  = mk(2'b00, 0, 0, 3'b000, 0, 0, 0, 3'b000, 0, 0, 0, 0, 1, 2);
    tbl[5]  = mk(2'b10, 0, 2, 3'b000, 0, 0, 0, 3'b000, 0, 0, 0, 1, 1, 3);
    tbl[6]  = mk(2'b11, 3, 4, 3'b000, 0, 0, 0, 3'b000, 0, 0, 0, 3, 1, 5);
    tbl[7]  = mk(2'b11, 5, 6, 3'b000, 0, 0, 0, 3'b000, 0, 0, 0, 5, 1, 7);
    tbl[8]  = mk(2'b11, 7, 8, 3'b000, 0, 0, 0, 3'b000, 0, 0, 0, 7, 1, 9);
    tbl[9]  = mk(2'b11, 9, 10, 3'b000, 0, 0, 0, 3'b000, 0, 0, 0, 9, 1, 11);
    tbl[10] = mk(2'b11, 11, 12, 3'b000, 0, 0, 0, 3'b000, 0, 0, 0, 11, 1, 13);
    tbl[11] = mk(2'b11, 13, 14, 3'b000, 0, 0, 0, 3'b000, 0, 0, 0, 13, 1, 15);
    tbl[12] = mk(2'b11, 15, 0, 3'b000, 0, 0, 0, 3'b000, 0, 0, 0, 15, 0, 1);
    tbl[13] = mk(2'b11, 1, 2, 3'b000, 0, 0, 0, 3'b000, 0, 0, 0, 15, 0, 1);
    tbl[14] = mk(2'b00, 0, 0, 3'b111, 2, 3, 4, 3'b000, 0, 0, 0, 15, 0, 1);
    tbl[15] = mk(2'b00, 0, 0, 3'b111, 5, 6, 7, 3'b111, 2, 3, 4, 12, 1, 1);
    tbl[16] = mk(2'b00, 0, 0, 3'b111, 8, 9, 10, 3'b111, 5, 6, 7, 9, 1, 1);
    tbl[17] = mk(2'b00, 0, 0, 3'b111, 11, 12, 13, 3'b111, 8, 9, 10, 6, 1, 1);
    tbl[18] = mk(2'b00, 0, 0, 3'b000, 0, 0, 0, 3'b111, 11, 12, 13, 3, 1, 1);
    tbl[19] = mk(2'b00, 0, 0, 3'b111, 14, 15, 0, 3'b000, 0, 0, 0, 3, 1, 1);
    tbl[20] = mk(2'b00, 0, 0, 3'b000, 0, 0, 0, 3'b111, 14, 15, 0, 0, 1, 1);
    tbl[21] = mk(2'b11, 1, 2, 3'b000, 0, 0, 0, 3'b000, 0, 0, 0, 2, 1, 3);
    tbl[22] = mk(2'b11, 3, 4, 3'b000, 0, 0, 0, 3'b000, 0, 0, 0, 4, 1, 5);
    tbl[23] = mk(2'b11, 5, 6, 3'b000, 0, 0, 0, 3'b000, 0, 0, 0, 6, 1, 7);
    tbl[24] = mk(2'b11, 7, 8, 3'b000, 0, 0, 0, 3'b000, 0, 0, 0, 8, 1, 9);
    tbl[25] = mk(2'b11, 9, 10, 3'b111, 1, 2, 3, 3'b000, 0, 0, 0, 10, 1, 11);
    tbl[26] = mk(2'b11, 11, 12, 3'b000, 0, 0, 0, 3'b111, 1, 2, 3, 9, 1, 13);
    tbl[27] = mk(2'b00, 0, 0, 3'b011, 5, 15, 0, 3'b000, 0, 0, 0, 9, 1, 13);
    tbl[28] = mk(2'b00, 0, 0, 3'b000, 0, 0, 0, 3'b000, 0, 0, 0, 9, 1, 13);
    tbl[29] = mk(2'b00, 0, 0, 3'b001, 4, 0, 0, 3'b000, 0, 0, 0, 9, 1, 13);
    tbl[30] = mk(2'b00, 0, 0, 3'b000, 0, 0, 0, 3'b011, 4, 5, 0, 7, 1, 13);
    tbl[31] = mk(2'b00, 0, 0, 3'b111, 6, 6, 7, 3'b000, 0, 0, 0, 7, 1, 13);
    tbl[32] = mk(2'b00, 0, 0, 3'b001, 8, 0, 0, 3'b011, 6, 7, 0, 5, 1, 13);
    tbl[33] = mk(2'b00, 0, 0, 3'b000, 0, 0, 0, 3'b001, 8, 0, 0, 4, 1, 13);
    tbl[34] = mk(2'b11, 13, 14, 3'b111, 9, 10, 11, 3'b000, 0, 0, 0, 6, 1, 15);
    tbl[35] = mk(2'b11, 15, 0, 3'b111, 12, 13, 14, 3'b111, 9, 10, 11, 5, 1, 1);
    tbl[36] = mk(2'b00, 0, 0, 3'b000, 0, 0, 0, 3'b111, 12, 13, 14, 2, 1, 1);
    tbl[37] = mk(2'b00, 0, 0, 3'b000, 0, 0, 0, 3'b000, 0, 0, 0, 2, 1, 1);
    idle();
    repeat (2) @(negedge clk);
    chk("reset count", 32'(count), 32'd0);
    chk("reset ready", 32'(disp_ready), 32'd1);
    chk("reset disp_idx", 32'(disp_idx), 32'h10);
    chk("reset ret_valid", 32'(ret_valid), 32'd0);
    chk("reset ret_pdst", 32'(ret_pdst), 32'd0);
    chk("reset ret_old", 32'(ret_old), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 38; i++) apply($sformatf("row%0d", i), tbl[i]);
    // entries 15 and 0 become done, then reset lands before they can retire
    wb_valid = 3'b011;
    wb_idx = {4'd0, 4'd0, 4'd15};
    @(posedge clk);
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    #1;
    chk("midreset count", 32'(count), 32'd0);
    chk("midreset ret_valid", 32'(ret_valid), 32'd0);
    chk("midreset disp_idx", 32'(disp_idx), 32'h10);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("postreset ret_valid", 32'(ret_valid), 32'd0);
    chk("postreset ret_old", 32'(ret_old), 32'd0);
    chk("postreset count", 32'(count), 32'd0);
`ifdef ROB_FLUSH_EN
    apply("fl0", mk(2'b11, 0, 1, 3'b000, 0, 0, 0, 3'b000, 0, 0, 0, 2, 1, 2));
    apply("fl1", mk(2'b11, 2, 3, 3'b000, 0, 0, 0, 3'b000, 0, 0, 0, 4, 1, 4));
    apply("fl2", mk(2'b01, 4, 0, 3'b011, 0, 1, 0, 3'b000, 0, 0, 0, 5, 1, 5));
    f = mk(2'b11, 5, 6, 3'b001, 2, 0, 0, 3'b000, 0, 0, 0, 0, 1, 0);
    flush = 1'b1;
    apply("flush", f);
    flush = 1'b0;
    apply("fl_disp", mk(2'b11, 0, 1, 3'b000, 0, 0, 0, 3'b000, 0, 0, 0, 2, 1, 2));
    apply("fl_idle", mk(2'b00, 0, 0, 3'b000, 0, 0, 0, 3'b000, 0, 0, 0, 2, 1, 2));
`else
    f = mk(2'b00, 0, 0, 3'b000, 0, 0, 0, 3'b000, 0, 0, 0, 0, 1, 0);
    apply("idle_end", f);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rob_retire_unit.md
Name: rob_retire_unit

Overview:
- Reorder buffer that sits directly downstream of the rename stage.
- Accepts up to 2 renamed instructions per cycle in program order and records completion writebacks from execute.
- Retires up to 3 completed instructions per cycle, in order, from the head.
- The registered retire outputs feed rename's free-pool release (old physical destination) and the architectural commit path.

Parameters:
DEPTH, 16, number of ROB entries; power of two, minimum 4
PREG_W, 7, physical register address width (128 PRegs)
IDX_W, $clog2(DEPTH), ROB index width (derived)

Ports:
i_clk  input  1  clock; all state updates on rising edge
i_rst_n  input  1  asynchronous, active-low reset
i_disp_valid  input  2  per-slot dispatch valid; slot 0 is older
i_disp_pdst  input  2xPREG_W  new physical destination per slot (0 = no destination)
i_disp_old_pdst  input  2xPREG_W  previous mapping of the destination, to be freed at retire
o_disp_ready  output  1  at least 2 free entries this cycle
o_disp_idx  output  2xIDX_W  ROB index assigned to slot 0 / slot 1 (tail, tail+1)
i_wb_valid  input  3  per-port completion valid
i_wb_idx  input  3xIDX_W  ROB index completing on each port
o_ret_valid  output  3  per-lane retire valid; lane 0 is oldest
o_ret_pdst  output  3xPREG_W  retired new destination
o_ret_old_pdst  output  3xPREG_W  retired old destination, to be released to the free pool
o_count  output  IDX_W+1  occupied entries

Behaviour:
- Storage:
  - Per entry: valid, done, pdst, old_pdst.
  - Head and tail pointers are IDX_W bits and wrap modulo DEPTH.
  - Count is IDX_W+1 bits.
- Reset (async assert, sync release):
  - All entry valid/done bits clear; head = tail = 0; count = 0.
  - o_ret_valid = 0; o_ret_pdst = o_ret_old_pdst = 0; o_disp_ready = 1.
- Dispatch:
  - o_disp_ready = (DEPTH - count) >= 2, computed from registered count only.
  - o_disp_idx is combinational: {tail, tail+1}.
  - Each slot with valid set and o_disp_ready high is written at the edge: valid = 1, done = 0.
  - Tail advances by popcount(i_disp_valid).
  - Slot 1 valid with slot 0 invalid: slot 1 takes index tail and tail advances by 1 (compaction).
  - Valid asserted while o_disp_ready is low: ignored, and no state changes.
- Completion:
  - Each valid wb port sets done for its index at the edge. The new done bit is visible to retire no earlier than the next cycle.
  - Duplicate indices across ports are legal (idempotent).
  - Writeback to an invalid entry is ignored.
- Retire:
  - Each cycle, examine head, head+1 and head+2 (modulo DEPTH).
  - Lane k retires if entries head..head+k are all valid and done. Retirement stops at the first entry that is not ready; there are no gaps.
  - Retired entries are cleared, head advances by the number retired, and outputs register at the same edge.
  - Latency: a writeback at edge N gives o_ret_valid at edge N+1 at the earliest, if that entry is at the head.
  - Non-retiring lanes drive o_ret_valid = 0 and zero data.
- Simultaneous events:
  - Dispatch and retire in the same cycle: count_next = count + dispatched - retired.
  - Retire-freed entries are not available to dispatch until the next cycle.
- Boundaries:
  - count = DEPTH-1: o_disp_ready = 0.
  - Full: head == tail with count = DEPTH.
  - Pointer wrap DEPTH-1 -> 0 applies to dispatch, retire and the 3-wide lookahead.
- Reset mid-operation discards all in-flight entries immediately; no retire outputs are produced for them.

Optional Feature:
- ROB_FLUSH_EN: adds input i_flush (1 bit).
- When i_flush is high at an edge:
  - All entries are invalidated; head = tail = 0; count = 0.
  - o_ret_valid is forced to 0 at that edge.
  - Dispatch and writeback in the same cycle are dropped.
- Flush has priority over all other updates.
- Without the macro: no port, and no flush logic is present.

Test Plan:
- Reset, then dispatch 2 (pdst 32/33, old 5/6) -> o_disp_idx = {0,1}, o_count = 2, no retire.
- Writeback idx 1 only -> no retire. Then writeback idx 0 -> next cycle o_ret_valid = 3'b011, old_pdst = {5,6}, o_count = 0.
- Dispatch 2 per cycle until count = 15 -> o_disp_ready = 0 at count 15; further valid dispatch leaves o_count = 15 and tail unchanged.
- Pointer wrap: head = 14, entries 14, 15, 0 done -> o_ret_valid = 3'b111 in one cycle, head = 1.
- Same cycle: dispatch 2 and retire 3 at count 10 -> o_count = 9 next cycle.
- ROB_FLUSH_EN: i_flush with 5 entries, 2 of them done -> o_count = 0, o_ret_valid = 0, and the next dispatch gets idx {0,1}.
